// File: rtl/direction_frame_decoder.sv
// direction_frame_decoder
// Validates {chk, copy, data} frames against their claimed parity, registers the
// decode in a one-entry stage, then queues the surviving directions in a FIFO.
// A run of ERR_LIMIT undecodable frames moves the block into a sticky FAULT state.
// In FAULT, corrected frames are discarded. Only a clean frame returns the block to RUN.
// Optional feature macro: DIR_DEC_STATS_EN builds the saturating corr/drop counters.
// Without it, both counters read 0 and no counter flops are built.
//
// state    | meaning
// ST_RUN   | normal decode; clean and corrected frames are enqueued
// ST_FAULT | sticky fault; only clean frames are enqueued, and a clean frame exits
module direction_frame_decoder #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned FRAME_W  = 2 + 2 * DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_dir,
  output logic               out_corrected,
  output logic               fault,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     consec_q, consec_d;
  logic              stage_valid_q, stage_valid_d;
  logic [DATA_W-1:0] stage_dir_q, stage_dir_d;
  logic              stage_corr_q, stage_corr_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [1:0]        chk;
  logic [DATA_W-1:0] copy_f;
  logic [DATA_W-1:0] data_f;
  logic              chk_ok, claim, is_clean, is_corr;
  logic              accept, push, pop;
  logic [CW-1:0]     occ;

  assign chk    = in_frame[FRAME_W-1 -: 2];
  assign copy_f = in_frame[2*DATA_W-1 -: DATA_W];
  assign data_f = in_frame[DATA_W-1:0];

  // chk 11 claims odd parity, 00 claims even; mixed codes can never validate
  assign chk_ok   = (chk[1] == chk[0]);
  assign claim    = chk[1];
  assign is_clean = chk_ok & ((^data_f) == claim);
  assign is_corr  = chk_ok & ~is_clean & ((^copy_f) == claim);

  // space is judged on registered occupancy only, so a pop frees room a cycle later
  assign occ       = count_q + CW'(stage_valid_q);
  assign in_ready  = (occ < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (count_q != '0);
  assign push      = stage_valid_q;
  assign pop       = out_valid & out_ready;
  assign fault     = (state_q == ST_FAULT);

  assign out_dir       = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
  assign out_corrected = out_valid & mem_q[rd_ptr_q][DATA_W];

  // decode classification, fault FSM next state and stage load
  always_comb begin
    state_d       = state_q;
    consec_d      = consec_q;
    stage_valid_d = 1'b0;
    stage_dir_d   = stage_dir_q;
    stage_corr_d  = stage_corr_q;
    if (accept) begin
      if (is_clean) begin
        consec_d      = '0;
        state_d       = ST_RUN;
        stage_valid_d = 1'b1;
        stage_dir_d   = data_f;
        stage_corr_d  = 1'b0;
      end else if (is_corr) begin
        consec_d = '0;
        if (state_q == ST_RUN) begin
          stage_valid_d = 1'b1;
          stage_dir_d   = copy_f;
          stage_corr_d  = 1'b1;
        end
      end else begin
        if (consec_q != EW'(ERR_LIMIT)) consec_d = consec_q + EW'(1);
        if (consec_q >= EW'(ERR_LIMIT - 1)) state_d = ST_FAULT;
      end
    end
  end

  // FIFO write from the stage, read on consumer handshake
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {stage_corr_q, stage_dir_q};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // state, stage and FIFO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      consec_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_dir_q   <= '0;
      stage_corr_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      consec_q      <= consec_d;
      stage_valid_q <= stage_valid_d;
      stage_dir_q   <= stage_dir_d;
      stage_corr_q  <= stage_corr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

`ifdef DIR_DEC_STATS_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             corr_ev, drop_ev;

  // a corrected frame seen in FAULT counts as a drop, not a correction
  assign corr_ev = accept & is_corr & (state_q == ST_RUN);
  assign drop_ev = accept & ~is_clean & ~corr_ev;

  // saturating statistics
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (corr_ev && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + CNT_W'(1);
    if (drop_ev && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign corr_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_direction_frame_decoder.sv
// tb_direction_frame_decoder
// Scoreboard bench: each accepted frame is decoded by a small reference model and the
// expected direction is queued; every FIFO pop is compared against the queue head.
// Counter expectations follow DIR_DEC_STATS_EN (0 when the statistics are not built).
module tb_direction_frame_decoder;

  localparam int DATA_W = 3;
  localparam int FW     = 2 + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     in_frame = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_dir;
  logic              out_corrected;
  logic              fault;
  logic [7:0]        corr_cnt;
  logic [7:0]        drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [DATA_W:0] sb[$];
  int m_consec = 0;
  int m_corr   = 0;
  int m_drop   = 0;
  bit m_fault  = 1'b0;

  direction_frame_decoder #(.DATA_W(3), .DEPTH(4), .ERR_LIMIT(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_frame(in_frame), .out_valid(out_valid), .out_ready(out_ready),
    .out_dir(out_dir), .out_corrected(out_corrected), .fault(fault),
    .corr_cnt(corr_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_corr();
`ifdef DIR_DEC_STATS_EN
    return m_corr;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_drop();
`ifdef DIR_DEC_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic model_accept(input logic [FW-1:0] f);
    logic [1:0] c;
    logic [DATA_W-1:0] cp, d;
    bit valid, odd, clean, corr;
    c  = f[FW-1:FW-2];
    cp = f[2*DATA_W-1:DATA_W];
    d  = f[DATA_W-1:0];
    valid = (c == 2'b11) || (c == 2'b00);
    odd   = (c == 2'b11);
    clean = valid && ((^d) == odd);
    corr  = valid && !clean && ((^cp) == odd);
    if (clean) begin
      sb.push_back({1'b0, d});
      m_consec = 0;
      m_fault  = 1'b0;
    end else if (corr) begin
      m_consec = 0;
      if (m_fault) m_drop++;
      else begin
        sb.push_back({1'b1, cp});
        m_corr++;
      end
    end else begin
      m_drop++;
      m_consec++;
      if (m_consec >= 3) m_fault = 1'b1;
    end
  endtask

  // handshakes are evaluated mid-cycle, where inputs and registered outputs are stable
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) model_accept(in_frame);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("unexpected_pop", {28'd0, out_corrected, out_dir}, 32'hFFFF);
        else begin
          logic [DATA_W:0] e;
          e = sb.pop_front();
          check_eq("pop_dir", out_dir, e[DATA_W-1:0]);
          check_eq("pop_corr", out_corrected, e[DATA_W]);
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the frame was taken
  task automatic send(input logic [FW-1:0] f);
    int n = 0;
    in_valid = 1'b1;
    in_frame = f;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check_eq("send_timeout", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
    idle(2);
    check_eq("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    int acc;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_out_dir", out_dir, 0);
    check_eq("rst_corr_cnt", corr_cnt, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // latency: accepted at cycle 0, visible at cycle 2
    out_ready = 1'b1;
    send(8'b11_000_001);
    @(negedge clk);
    check_eq("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", out_valid, 1);
    check_eq("lat_dir", out_dir, 3'b001);
    check_eq("lat_corr", out_corrected, 0);
    @(posedge clk); #1;

    // corrected and even-parity frames
    send(8'b11_010_011);
    send(8'b00_111_011);
    drain();
    check_eq("corr_cnt_after_corr", corr_cnt, exp_corr());

    // drops: bad parity on both copies, then invalid chk
    send(8'b11_011_011);
    send(8'b01_001_001);
    idle(4);
    check_eq("drop_out_valid", out_valid, 0);
    check_eq("drop_cnt_two", drop_cnt, exp_drop());
    check_eq("drop_fault", fault, m_fault);

    // backpressure: only DEPTH frames fit
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_frame = {2'b11, 3'b000, 3'(i + 1)};
      if (^in_frame[2:0] == 1'b0) in_frame[7:6] = 2'b00;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", acc, 4);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    drain();

    // push and pop in the same cycle at count 2
    out_ready = 1'b0;
    send(8'b11_000_100);
    send(8'b11_000_111);
    send(8'b00_000_110);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle(2);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_frame = 8'b00_000_101;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("pp_free_slots", acc, 2);
    drain();

    // fault entry, corrected drop in fault, clean exit
    for (int i = 0; i < 3; i++) send(8'b11_011_011);
    @(negedge clk);
    check_eq("fault_set", fault, 1);
    @(posedge clk); #1;
    send(8'b11_010_011);
    idle(3);
    check_eq("fault_corr_dropped", out_valid, 0);
    check_eq("fault_drop_cnt", drop_cnt, exp_drop());
    check_eq("fault_corr_cnt", corr_cnt, exp_corr());
    check_eq("fault_held", fault, 1);
    send(8'b11_100_100);
    @(negedge clk);
    check_eq("fault_cleared", fault, 0);
    @(posedge clk); #1;
    drain();

    // async reset with entries queued and fault raised
    out_ready = 1'b0;
    send(8'b11_000_001);
    send(8'b11_000_010);
    send(8'b11_000_100);
    for (int i = 0; i < 3; i++) send(8'b01_000_000);
    idle(2);
    check_eq("pre_rst_fault", fault, m_fault);
    check_eq("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_fault", fault, 0);
    check_eq("arst_corr_cnt", corr_cnt, 0);
    check_eq("arst_drop_cnt", drop_cnt, 0);
    sb.delete();
    m_consec = 0; m_corr = 0; m_drop = 0; m_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    check_eq("post_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    send(8'b00_000_011);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
